he_poly_dma: RTL and testbench
==============================

Name: he_poly_dma

Overview:
- Parametrised memory front-end for the HE relinearization accelerator.
- Load side: on start, fetches NUM_POLYS polynomials of DEGREE_N coefficients from memory into an internal coefficient bank, then exposes the bank tile-by-tile to the poly-mul engine.
- Store side: drains engine results (NUM_OUT coefficients) back to memory through a one-entry buffer.
- Signals completion once both sides finish.

Parameters:
- BIT_WIDTH, 32, coefficient width.
- DEGREE_N, 16, coefficients per polynomial (power of 2).
- TILE_N, 4, coefficients per tile; divides DEGREE_N.
- NUM_POLYS, 6, polynomials loaded (key limbs plus ciphertext parts).
- NUM_OUT, 32, result coefficients to store.
- ADDR_BITS, 32, memory address width.
- ADDR_STRIDE, 4, byte increment per coefficient.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- start_i  in  1  begin job (sampled in IDLE only)
- src_base_i  in  ADDR_BITS  load base address, latched at start
- dst_base_i  in  ADDR_BITS  store base address, latched at start
- ready_o  out  1  high in IDLE
- load_done_o  out  1  bank fully loaded (sticky until IDLE)
- done_o  out  1  one-cycle job-complete pulse
- mem_read_o  out  1  read request
- addr_read_o  out  ADDR_BITS  read address
- data_i  in  BIT_WIDTH  read data
- mem_resp_read_i  in  1  read response
- rd_poly_i  in  clog2(NUM_POLYS)  bank polynomial select
- rd_tile_i  in  clog2(DEGREE_N/TILE_N)  bank tile select
- tile_o  out  TILE_N*BIT_WIDTH  selected tile, registered
- res_valid_i  in  1  result coefficient valid
- res_data_i  in  BIT_WIDTH  result coefficient
- res_ready_o  out  1  store buffer can accept
- mem_write_o  out  1  write request
- addr_write_o  out  ADDR_BITS  write address
- data_o  out  BIT_WIDTH  write data
- mem_resp_write_i  in  1  write response

Behaviour:
- Reset (rst==0 at posedge): state=IDLE, all counters 0, buffer empty, every output 0 except ready_o=1. Bank contents are not cleared. Reset mid-job aborts immediately, with no further requests.
- FSM states IDLE, RUN, DONE.
  - IDLE→RUN on start_i; latches both base addresses.
  - RUN→DONE when load_cnt==NUM_POLYS*DEGREE_N and store_cnt==NUM_OUT.
  - DONE→IDLE unconditionally after one cycle; done_o=1 only in DONE.
- start_i outside IDLE is ignored.
- Load, in RUN while load_cnt<NUM_POLYS*DEGREE_N:
  - mem_read_o=1, addr_read_o=src_base+load_cnt*ADDR_STRIDE (mod 2^ADDR_BITS).
  - Request is held until mem_resp_read_i.
  - On a response, data_i is written to bank[load_cnt/DEGREE_N][load_cnt%DEGREE_N] and load_cnt increments. The next request is issued the following cycle at the new address.
  - mem_resp_read_i while mem_read_o==0 is ignored.
  - After the last response, mem_read_o=0 and load_done_o=1 from the next cycle until IDLE.
- Tile read: tile_o <= bank[rd_poly_i][rd_tile_i*TILE_N +: TILE_N], one-cycle latency, updated every cycle. Coefficient 0 of the tile occupies the LSBs. Valid data only once load_done_o is high; not gated.
- Store: one-entry buffer.
  - res_ready_o = (state==RUN) & buffer empty & store_cnt+buffer-occupancy<NUM_OUT.
  - A handshake (res_valid_i & res_ready_o) loads the buffer.
  - While full: mem_write_o=1, data_o=buffer, addr_write_o=dst_base+store_cnt*ADDR_STRIDE.
  - On mem_resp_write_i the buffer empties and store_cnt increments. Accept is not allowed in the same cycle, so throughput is at most 1 per 2 cycles.
  - Results may arrive before load completes; load and store run concurrently.
  - mem_resp_write_i with no pending write is ignored.
- Counters: load_cnt width clog2(NUM_POLYS*DEGREE_N+1), store_cnt width clog2(NUM_OUT+1). Neither wraps.
- If load and store finish in the same cycle, DONE is entered the next cycle.

Test Plan:
- Reset then idle: rst=0 for 2 cycles → ready_o=1, mem_read_o=0, mem_write_o=0, done_o=0, res_ready_o=0.
- Load with 0-wait memory, DEGREE_N=16, NUM_POLYS=6, src_base=0x1000:
  - 96 requests at addresses 0x1000, 0x1004 … 0x117C.
  - load_done_o rises after the 96th response.
  - rd_poly_i=2, rd_tile_i=3 returns coefficients 44..47 one cycle later.
- Load with 3-cycle response latency:
  - Address stays constant while waiting.
  - Spurious mem_resp_read_i during idle gaps or after load completes writes nothing to the bank and does not advance load_cnt.
- Store of NUM_OUT=32 results with res_valid_i held high, dst_base=0x2000:
  - Writes go to 0x2000..0x207C in order with matching data.
  - res_ready_o is low while a write is pending.
  - done_o pulses once after both sides finish; ready_o=1 the next cycle.
- Results arriving before load completes are stored correctly, and done_o waits for the final load response.
- Reset asserted mid-load at load_cnt=40: next cycle IDLE, no requests. A new start_i restarts at src_base with load_cnt=0.

Source files
------------

// File: rtl/he_poly_dma.sv
// Memory front-end for the HE relinearization accelerator: loads polynomials into a coefficient
// bank served tile-by-tile to the poly-mul engine, and stores engine results via a 1-entry buffer.
module he_poly_dma #(
  parameter int unsigned BIT_WIDTH   = 32,
  parameter int unsigned DEGREE_N    = 16,
  parameter int unsigned TILE_N      = 4,
  parameter int unsigned NUM_POLYS   = 6,
  parameter int unsigned NUM_OUT     = 32,
  parameter int unsigned ADDR_BITS   = 32,
  parameter int unsigned ADDR_STRIDE = 4
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start_i,
  input  logic [ADDR_BITS-1:0]                    src_base_i,
  input  logic [ADDR_BITS-1:0]                    dst_base_i,
  output logic                                    ready_o,
  output logic                                    load_done_o,
  output logic                                    done_o,
  output logic                                    mem_read_o,
  output logic [ADDR_BITS-1:0]                    addr_read_o,
  input  logic [BIT_WIDTH-1:0]                    data_i,
  input  logic                                    mem_resp_read_i,
  input  logic [$clog2(NUM_POLYS)-1:0]            rd_poly_i,
  input  logic [$clog2(DEGREE_N/TILE_N)-1:0]      rd_tile_i,
  output logic [TILE_N*BIT_WIDTH-1:0]             tile_o,
  input  logic                                    res_valid_i,
  input  logic [BIT_WIDTH-1:0]                    res_data_i,
  output logic                                    res_ready_o,
  output logic                                    mem_write_o,
  output logic [ADDR_BITS-1:0]                    addr_write_o,
  output logic [BIT_WIDTH-1:0]                    data_o,
  input  logic                                    mem_resp_write_i
);
  localparam int unsigned TotalLoad = NUM_POLYS * DEGREE_N;
  localparam int unsigned LoadW     = $clog2(TotalLoad + 1);
  localparam int unsigned StoreW    = $clog2(NUM_OUT + 1);
  localparam int unsigned CoefW     = $clog2(DEGREE_N);
  localparam int unsigned PolyW     = $clog2(NUM_POLYS);
  localparam int unsigned TOffW     = $clog2(TILE_N);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                      state_q, state_d;
  logic [ADDR_BITS-1:0]        src_q, src_d, dst_q, dst_d;
  logic [LoadW-1:0]            load_cnt_q, load_cnt_d;
  logic [StoreW-1:0]           store_cnt_q, store_cnt_d;
  logic                        buf_full_q, buf_full_d;
  logic [BIT_WIDTH-1:0]        buf_q, buf_d;
  logic [TILE_N*BIT_WIDTH-1:0] tile_q, tile_d;
  logic [BIT_WIDTH-1:0]        bank_q [NUM_POLYS][DEGREE_N];

  logic             load_full, store_full, load_busy, load_fire, res_fire, wr_fire;
  logic [PolyW-1:0] wr_poly;
  logic [CoefW-1:0] wr_coef;

  assign load_full  = load_cnt_q == LoadW'(TotalLoad);
  assign store_full = store_cnt_q == StoreW'(NUM_OUT);
  assign load_busy  = (state_q == StRun) && !load_full;
  assign load_fire  = load_busy && mem_resp_read_i;
  // The buffer is empty whenever ready is considered, so occupancy adds nothing to store_cnt.
  assign res_ready_o = (state_q == StRun) && !buf_full_q && !store_full;
  assign res_fire    = res_valid_i && res_ready_o;
  assign wr_fire     = buf_full_q && mem_resp_write_i;
  assign wr_poly     = PolyW'(load_cnt_q >> CoefW);
  assign wr_coef     = load_cnt_q[CoefW-1:0];

  assign ready_o      = state_q == StIdle;
  assign done_o       = state_q == StDone;
  assign load_done_o  = (state_q != StIdle) && load_full;
  assign mem_read_o   = load_busy;
  assign addr_read_o  = load_busy ?
                        src_q + ADDR_BITS'(load_cnt_q) * ADDR_BITS'(ADDR_STRIDE) : '0;
  assign mem_write_o  = buf_full_q;
  assign addr_write_o = buf_full_q ?
                        dst_q + ADDR_BITS'(store_cnt_q) * ADDR_BITS'(ADDR_STRIDE) : '0;
  assign data_o       = buf_full_q ? buf_q : '0;
  assign tile_o       = tile_q;

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    load_cnt_d  = load_cnt_q;
    store_cnt_d = store_cnt_q;
    buf_full_d  = buf_full_q;
    buf_d       = buf_q;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d     = StRun;
          src_d       = src_base_i;
          dst_d       = dst_base_i;
          load_cnt_d  = '0;
          store_cnt_d = '0;
        end
      end
      StRun:   if (load_full && store_full) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (load_fire) load_cnt_d = load_cnt_q + 1'b1;
    // A write response frees the buffer; refill can only happen on a later cycle.
    if (wr_fire) begin
      buf_full_d  = 1'b0;
      store_cnt_d = store_cnt_q + 1'b1;
    end else if (res_fire) begin
      buf_full_d = 1'b1;
      buf_d      = res_data_i;
    end
  end

  always_comb begin
    tile_d = '0;
    for (int t = 0; t < TILE_N; t++) begin
      tile_d[t*BIT_WIDTH +: BIT_WIDTH] = bank_q[rd_poly_i][{rd_tile_i, TOffW'(t)}];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      src_q       <= '0;
      dst_q       <= '0;
      load_cnt_q  <= '0;
      store_cnt_q <= '0;
      buf_full_q  <= 1'b0;
      buf_q       <= '0;
      tile_q      <= '0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      load_cnt_q  <= load_cnt_d;
      store_cnt_q <= store_cnt_d;
      buf_full_q  <= buf_full_d;
      buf_q       <= buf_d;
      tile_q      <= tile_d;
    end
  end

  // Bank contents survive reset; only the write is suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst && load_fire) bank_q[wr_poly][wr_coef] <= data_i;
  end
endmodule

// File: tb/tb_he_poly_dma.sv
// Scoreboard bench for he_poly_dma: memory models on both sides, expected stores queued at
// handshake and popped at write, bank contents checked through the tile port.
module tb_he_poly_dma;
  localparam int unsigned DEG = 16, TILE = 4, NP = 6, NOUT = 32, STRIDE = 4;
  localparam int TOTAL = NP * DEG;

  logic         clk = 1'b0, rst = 1'b0, start_i = 1'b0;
  logic [31:0]  src_base_i = '0, dst_base_i = '0, data_i = '0, res_data_i = '0;
  logic         mem_resp_read_i = 1'b0, res_valid_i = 1'b0, mem_resp_write_i = 1'b0;
  logic [2:0]   rd_poly_i = '0;
  logic [1:0]   rd_tile_i = '0;
  logic         ready_o, load_done_o, done_o, mem_read_o, res_ready_o, mem_write_o;
  logic [31:0]  addr_read_o, addr_write_o, data_o;
  logic [127:0] tile_o;

  int passed = 0, total = 0;

  typedef struct packed {logic [31:0] addr; logic [31:0] data;} wr_t;
  wr_t wr_q[$];

  always #5 clk = ~clk;

  he_poly_dma dut (
    .clk(clk), .rst(rst), .start_i(start_i), .src_base_i(src_base_i), .dst_base_i(dst_base_i),
    .ready_o(ready_o), .load_done_o(load_done_o), .done_o(done_o), .mem_read_o(mem_read_o),
    .addr_read_o(addr_read_o), .data_i(data_i), .mem_resp_read_i(mem_resp_read_i),
    .rd_poly_i(rd_poly_i), .rd_tile_i(rd_tile_i), .tile_o(tile_o), .res_valid_i(res_valid_i),
    .res_data_i(res_data_i), .res_ready_o(res_ready_o), .mem_write_o(mem_write_o),
    .addr_write_o(addr_write_o), .data_o(data_o), .mem_resp_write_i(mem_resp_write_i)
  );

  function automatic logic [127:0] exp_tile(input int p, input int t, input logic [31:0] salt);
    logic [127:0] v;
    for (int i = 0; i < TILE; i++) v[i*32 +: 32] = salt + 32'(p * DEG + t * TILE + i);
    return v;
  endfunction

  task automatic read_tile(input int p, input int t, output logic [127:0] v);
    @(negedge clk);
    rd_poly_i = 3'(p);
    rd_tile_i = 2'(t);
    @(negedge clk);
    v = tile_o;
  endtask

  // Drives one job to completion; memory data = salt + coefficient index.
  task automatic run_job(input logic [31:0] src, input logic [31:0] dst, input int lat,
                         input int res_start, input bit spurious, input logic [31:0] salt,
                         input string tag);
    int ld, acc, st, wc, cyc, cmpl;
    bit full, fin;
    wr_t e;
    logic [31:0] a;
    ld = 0; acc = 0; st = 0; wc = 0; cyc = 0; cmpl = 1 << 30; full = 0; fin = 0;
    wr_q.delete();
    @(negedge clk);
    start_i = 1; src_base_i = src; dst_base_i = dst;
    while (!fin) begin
      @(negedge clk);
      cyc++;
      start_i = 0; mem_resp_read_i = 0; mem_resp_write_i = 0; res_valid_i = 0; data_i = '0;
      if (cyc == 10) begin  // start outside IDLE must not relatch bases
        start_i = 1; src_base_i = ~src; dst_base_i = ~dst;
      end
      if (ld == TOTAL && st == NOUT && cmpl == (1 << 30)) cmpl = cyc;
      total++;
      if (done_o !== 1'(cyc == cmpl + 1))
        $display("FAIL %s done_o cyc %0d: got %b want %b", tag, cyc, done_o, cyc == cmpl + 1);
      else passed++;
      if (cyc == cmpl + 2) begin
        total++;
        if (ready_o !== 1'b1 || load_done_o !== 1'b0 || mem_read_o !== 1'b0)
          $display("FAIL %s post_done: got rdy=%b ld_done=%b rd=%b want 1 0 0", tag, ready_o,
                   load_done_o, mem_read_o);
        else passed++;
        fin = 1;
      end else begin
        total++;
        if (mem_read_o !== 1'(ld < TOTAL) || load_done_o !== 1'(ld == TOTAL))
          $display("FAIL %s read_status cyc %0d: got rd=%b ld_done=%b want %b %b", tag, cyc,
                   mem_read_o, load_done_o, ld < TOTAL, ld == TOTAL);
        else passed++;
        total++;
        if (mem_write_o !== full || res_ready_o !== 1'(!full && acc < NOUT && cyc <= cmpl)
            || ready_o !== 1'b0)
          $display("FAIL %s store_status cyc %0d: got wr=%b res_rdy=%b rdy=%b want %b %b 0",
                   tag, cyc, mem_write_o, res_ready_o, ready_o, full,
                   !full && acc < NOUT && cyc <= cmpl);
        else passed++;
        if (mem_read_o === 1'b1 && ld < TOTAL) begin
          a = src + 32'(ld * STRIDE);
          total++;
          if (addr_read_o !== a)
            $display("FAIL %s addr_read #%0d: got %h want %h", tag, ld, addr_read_o, a);
          else passed++;
          if (wc == lat) begin
            mem_resp_read_i = 1; data_i = salt + 32'(ld); ld++; wc = 0;
          end else wc++;
        end else if (spurious && cyc % 2 == 1) begin
          mem_resp_read_i = 1; data_i = 32'hDEAD_BEEF;
        end
        if (mem_write_o === 1'b1 && full) begin
          total++;
          if (wr_q.size() == 0) $display("FAIL %s write: got write want none queued", tag);
          else begin
            e = wr_q.pop_front();
            if (addr_write_o !== e.addr || data_o !== e.data)
              $display("FAIL %s write #%0d: got %h/%h want %h/%h", tag, st, addr_write_o,
                       data_o, e.addr, e.data);
            else passed++;
          end
          mem_resp_write_i = 1; full = 0; st++;
        end else if (spurious && cyc % 2 == 0) mem_resp_write_i = 1;
        if (cyc >= res_start && acc < NOUT) begin
          res_valid_i = 1; res_data_i = 32'hC000_0000 + salt + 32'(acc);
          if (res_ready_o === 1'b1) begin
            wr_q.push_back('{addr: dst + 32'(acc * STRIDE), data: res_data_i});
            acc++; full = 1;
          end
        end
        if (cyc > 3000) begin
          total++;
          $display("FAIL %s timeout: got ld=%0d st=%0d want %0d %0d", tag, ld, st, TOTAL, NOUT);
          fin = 1;
        end
      end
    end
    start_i = 0; mem_resp_read_i = 0; mem_resp_write_i = 0; res_valid_i = 0;
    total++;
    if (wr_q.size() != 0) $display("FAIL %s leftover: got %0d want 0", tag, wr_q.size());
    else passed++;
  endtask

  task automatic test_reset;
    rst = 0;
    repeat (2) @(negedge clk);
    total++;
    if (ready_o !== 1'b1 || mem_read_o !== 1'b0 || mem_write_o !== 1'b0 || done_o !== 1'b0
        || res_ready_o !== 1'b0 || load_done_o !== 1'b0 || tile_o !== '0)
      $display("FAIL reset: got rdy=%b rd=%b wr=%b done=%b res_rdy=%b ld_done=%b tile=%h",
               ready_o, mem_read_o, mem_write_o, done_o, res_ready_o, load_done_o, tile_o);
    else passed++;
    rst = 1;
  endtask

  task automatic test_load_store;
    logic [127:0] v;
    int ps[3] = '{2, 5, 0};
    int ts[3] = '{3, 0, 0};
    run_job(32'h1000, 32'h2000, 0, 120, 0, 32'h0, "load_store");
    for (int i = 0; i < 3; i++) begin
      read_tile(ps[i], ts[i], v);
      total++;
      if (v !== exp_tile(ps[i], ts[i], 32'h0))
        $display("FAIL tile p%0d t%0d: got %h want %h", ps[i], ts[i], v,
                 exp_tile(ps[i], ts[i], 32'h0));
      else passed++;
    end
  endtask

  task automatic test_latency_spurious;
    logic [127:0] v;
    @(negedge clk);
    mem_resp_read_i = 1; mem_resp_write_i = 1; data_i = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    total++;
    if (mem_read_o !== 1'b0 || ready_o !== 1'b1)
      $display("FAIL idle_spurious: got rd=%b rdy=%b want 0 1", mem_read_o, ready_o);
    else passed++;
    mem_resp_read_i = 0; mem_resp_write_i = 0;
    run_job(32'h0001_0100, 32'h3000, 3, 420, 1, 32'h100, "latency");
    for (int p = 0; p < NP; p++)
      for (int t = 0; t < DEG / TILE; t++) begin
        read_tile(p, t, v);
        total++;
        if (v !== exp_tile(p, t, 32'h100))
          $display("FAIL bank p%0d t%0d: got %h want %h", p, t, v, exp_tile(p, t, 32'h100));
        else passed++;
      end
  endtask

  task automatic test_early_results;
    run_job(32'h4000, 32'h5000, 3, 1, 0, 32'h200, "early_results");
  endtask

  task automatic test_reset_mid_load;
    int ld = 0, guard = 0;
    @(negedge clk);
    start_i = 1; src_base_i = 32'h6000; dst_base_i = 32'h7000;
    @(negedge clk);
    start_i = 0;
    while (ld < 40 && guard < 200) begin
      mem_resp_read_i = 0;
      if (mem_read_o === 1'b1) begin
        data_i = 32'(ld); mem_resp_read_i = 1; ld++;
      end
      guard++;
      @(negedge clk);
    end
    mem_resp_read_i = 0;
    rst = 0;
    @(negedge clk);
    rst = 1;
    total++;
    if (ld != 40 || ready_o !== 1'b1 || mem_read_o !== 1'b0 || load_done_o !== 1'b0)
      $display("FAIL mid_reset: got ld=%0d rdy=%b rd=%b ld_done=%b want 40 1 0 0", ld,
               ready_o, mem_read_o, load_done_o);
    else passed++;
    repeat (2) begin
      @(negedge clk);
      total++;
      if (mem_read_o !== 1'b0 || mem_write_o !== 1'b0)
        $display("FAIL mid_reset_idle: got rd=%b wr=%b want 0 0", mem_read_o, mem_write_o);
      else passed++;
    end
    run_job(32'h6000, 32'h7000, 0, 1, 0, 32'h300, "restart");
  endtask

  task automatic test_addr_wrap;
    run_job(32'hFFFF_FFC0, 32'hFFFF_FFF0, 1, 5, 0, 32'h400, "addr_wrap");
  endtask

  initial begin
    test_reset();
    test_load_store();
    test_latency_spurious();
    test_early_results();
    test_reset_mid_load();
    test_addr_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish before 1ms");
    $fatal(1);
  end
endmodule
